i2s_tx: RTL

Stereo I2S transmitter feeding the DAC from the filtered audio path. Sits directly downstream of the digital filtering stage: it accepts one 24-bit left/right sample pair per frame through a valid/ready handshake, holds it in a one-deep pending buffer, and serialises it MSB-first in I2S format. It generates its own `bck`/`lrck` at the same rates as the receive side (clk/4 and clk/256).

---
 rtl/i2s_pkg.sv | 22 ++
 rtl/i2s_tx_shifter.sv | 39 +++
 rtl/i2s_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: clock ratios, slot geometry and the stereo sample type
// used by the receiver, the filter and the transmitter.
`timescale 1ns/1ps
package i2s_pkg;

    localparam int SAMPLE_W_DEF = 24;
    localparam int BCK_DIV      = 4;
    localparam int FRAME_CLKS   = 256;
    localparam int SLOTS_PER_CH = 32;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
    } stereo_sample_t;

    // Slot 0 is the I2S one-bit delay; slots 1..width carry the word MSB-first.
    function automatic logic slot_has_data(input logic [4:0] slot, input int unsigned width);
        return (slot != 5'd0) && ({27'd0, slot} <= width)
               && (width < 32'(SLOTS_PER_CH));
    endfunction

endpackage

// File: rtl/i2s_tx_shifter.sv
// One channel's output shifter: parallel load of a sample word, then shifts
// left with zero fill; the serial bit is always the current MSB.
`timescale 1ns/1ps
module i2s_tx_shifter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_data,
    output logic         msb
);

    logic [W-1:0] sh_d;
    logic [W-1:0] sh_q;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_data;
        end else if (shift) begin
            sh_d = {sh_q[W-2:0], 1'b0};
        end else begin
            sh_d = sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb = sh_q[W-1];

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter with a one-deep pending buffer and an underrun counter.
// Define I2S_TX_HOLD_EN to replay the previous sample on underrun instead of silence.
`timescale 1ns/1ps
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int UCNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                in_ready,
    output logic                bck,
    output logic                lrck,
    output logic                dout,
    output logic                frame_start,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_cnt
);

    logic [7:0]          p_d, p_q;
    logic                pend_full_d, pend_full_q;
    logic [SAMPLE_W-1:0] pend_l_d, pend_l_q, pend_r_d, pend_r_q;
    logic                in_ready_d, in_ready_q;
    logic                dout_d, dout_q;
    logic                frame_start_d, frame_start_q;
    logic                underrun_d, underrun_q;
    logic [UCNT_W-1:0]   ucnt_d, ucnt_q;
    logic [SAMPLE_W-1:0] act_l_s, act_r_s;
    logic                load_s, xfer_s, bit_edge_s, data_slot_s;
    logic                shift_l_s, shift_r_s, msb_l_s, msb_r_s;
`ifdef I2S_TX_HOLD_EN
    logic [SAMPLE_W-1:0] act_l_d, act_l_q, act_r_d, act_r_q;
`endif

    always_comb begin
        p_d         = p_q + 8'd1;
        load_s      = (p_q == 8'hFF);
        xfer_s      = in_valid && in_ready_q;
        // dout only moves on the edge into p[1:0]==00, so look one slot ahead.
        bit_edge_s  = (p_q[1:0] == 2'b11);
        data_slot_s = slot_has_data(p_d[6:2], 32'(SAMPLE_W));
        shift_l_s   = bit_edge_s && data_slot_s && !p_d[7];
        shift_r_s   = bit_edge_s && data_slot_s && p_d[7];

        pend_full_d = pend_full_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        if (load_s && pend_full_q) begin
            pend_full_d = 1'b0;
        end else if (xfer_s) begin
            pend_full_d = 1'b1;
            pend_l_d    = in_left;
            pend_r_d    = in_right;
        end else begin
            pend_full_d = pend_full_q;
        end

        if (pend_full_q) begin
            act_l_s = pend_l_q;
            act_r_s = pend_r_q;
        end else begin
`ifdef I2S_TX_HOLD_EN
            act_l_s = act_l_q;
            act_r_s = act_r_q;
`else
            act_l_s = '0;
            act_r_s = '0;
`endif
        end

`ifdef I2S_TX_HOLD_EN
        act_l_d = load_s ? act_l_s : act_l_q;
        act_r_d = load_s ? act_r_s : act_r_q;
`endif

        ucnt_d = ucnt_q;
        if (load_s && !pend_full_q && (ucnt_q != {UCNT_W{1'b1}})) begin
            ucnt_d = ucnt_q + {{(UCNT_W-1){1'b0}}, 1'b1};
        end else begin
            ucnt_d = ucnt_q;
        end

        dout_d = dout_q;
        if (bit_edge_s) begin
            dout_d = data_slot_s ? (p_d[7] ? msb_r_s : msb_l_s) : 1'b0;
        end else begin
            dout_d = dout_q;
        end

        in_ready_d    = !pend_full_d;
        frame_start_d = (p_d == 8'hFF);
        underrun_d    = (p_d == 8'hFF) && !pend_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q           <= 8'd0;
            pend_full_q   <= 1'b0;
            pend_l_q      <= '0;
            pend_r_q      <= '0;
            in_ready_q    <= 1'b0;
            dout_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            ucnt_q        <= '0;
`ifdef I2S_TX_HOLD_EN
            act_l_q       <= '0;
            act_r_q       <= '0;
`endif
        end else begin
            p_q           <= p_d;
            pend_full_q   <= pend_full_d;
            pend_l_q      <= pend_l_d;
            pend_r_q      <= pend_r_d;
            in_ready_q    <= in_ready_d;
            dout_q        <= dout_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            ucnt_q        <= ucnt_d;
`ifdef I2S_TX_HOLD_EN
            act_l_q       <= act_l_d;
            act_r_q       <= act_r_d;
`endif
        end
    end

    i2s_tx_shifter #(.W(SAMPLE_W)) u_shift_l (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .shift     (shift_l_s),
        .load_data (act_l_s),
        .msb       (msb_l_s)
    );

    i2s_tx_shifter #(.W(SAMPLE_W)) u_shift_r (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .shift     (shift_r_s),
        .load_data (act_r_s),
        .msb       (msb_r_s)
    );

    assign bck          = p_q[1];
    assign lrck         = p_q[7];
    assign in_ready     = in_ready_q;
    assign dout         = dout_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule
